// File: rtl/hsv_pwm_fader.sv
// HSV hue-wheel generator driving an RGB LED through three glitch-free PWM channels.
// Hue sweeps linearly inside each 60 degree sector; PWM duty is latched once per PWM period.
module hsv_pwm_fader #(
  parameter int CLK_HZ     = 12000000,
  parameter int CYCLE_MS   = 1000,
  parameter int PWM_BITS   = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       dir,
  output logic       RGB_R,
  output logic       RGB_G,
  output logic       RGB_B,
  output logic [2:0] sector,
  output logic       hue_wrap
);

  localparam int N        = PWM_BITS;
  localparam int STEPS    = 6 * (2 ** N);
  localparam int STEP_DIV = (CLK_HZ / 1000 * CYCLE_MS) / STEPS;
  localparam int HUE_W    = $clog2(STEPS);
  localparam int DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [HUE_W-1:0] HUE_LAST = HUE_W'(STEPS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [N:0]       FULL     = (N + 1)'(2 ** N);

  if (STEP_DIV < 1) begin : g_step_div_check
    $error("hsv_pwm_fader: clock too slow for requested CYCLE_MS/PWM_BITS (STEP_DIV < 1)");
  end

  typedef struct packed {
    logic [N:0] r;
    logic [N:0] g;
    logic [N:0] b;
  } rgb_lvl_t;

  logic [DIV_W-1:0] div_cnt;
  logic             step_tick;
  logic [HUE_W-1:0] hue;
  logic [N:0]       frac;
  rgb_lvl_t         lvl_next;
  rgb_lvl_t         lvl_q;
  logic [N-1:0]     pwm_cnt;
  logic             pwm_last;
  logic             on_r, on_g, on_b;

  // Step divider: cleared and held while frozen so a resume always waits a full STEP_DIV.
  assign step_tick = en && (div_cnt == DIV_LAST);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!en || step_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hue      <= '0;
      hue_wrap <= 1'b0;
    end else begin
      hue_wrap <= 1'b0;
      if (step_tick) begin
        if (dir) begin
          if (hue == HUE_LAST) begin
            hue      <= '0;
            hue_wrap <= 1'b1;
          end else begin
            hue <= hue + 1'b1;
          end
        end else begin
          if (hue == '0) begin
            hue      <= HUE_LAST;
            hue_wrap <= 1'b1;
          end else begin
            hue <= hue - 1'b1;
          end
        end
      end
    end
  end

  assign sector = 3'(hue >> N);
  assign frac   = {1'b0, hue[N-1:0]};

  // NOTE: defaults first so every path assigns every field and no latch is inferred.
  always_comb begin
    lvl_next = '0;
    case (sector)
      3'd0: begin lvl_next.r = FULL;        lvl_next.g = frac;        end
      3'd1: begin lvl_next.r = FULL - frac; lvl_next.g = FULL;        end
      3'd2: begin lvl_next.g = FULL;        lvl_next.b = frac;        end
      3'd3: begin lvl_next.g = FULL - frac; lvl_next.b = FULL;        end
      3'd4: begin lvl_next.r = frac;        lvl_next.b = FULL;        end
      3'd5: begin lvl_next.r = FULL;        lvl_next.b = FULL - frac; end
      default: ;
    endcase
  end

  // Levels are N+1 bits so FULL compares above every count value (always on).
  assign pwm_last = &pwm_cnt;
  assign on_r     = {1'b0, pwm_cnt} < lvl_q.r;
  assign on_g     = {1'b0, pwm_cnt} < lvl_q.g;
  assign on_b     = {1'b0, pwm_cnt} < lvl_q.b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      lvl_q   <= '0;
      RGB_R   <= ACTIVE_LOW;
      RGB_G   <= ACTIVE_LOW;
      RGB_B   <= ACTIVE_LOW;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_last) begin
        lvl_q <= lvl_next;
      end
      RGB_R <= on_r ^ ACTIVE_LOW;
      RGB_G <= on_g ^ ACTIVE_LOW;
      RGB_B <= on_b ^ ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_hsv_pwm_fader.sv
// Directed bench for hsv_pwm_fader with PWM_BITS=2, STEP_DIV=1000 (24 hue steps).
// Cycle k means "sampled 1 ns after the k-th rising edge following reset release".
module tb_hsv_pwm_fader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic       rgb_r, rgb_g, rgb_b;
  logic [2:0] sector;
  logic       hue_wrap;
  logic [2:0] rgb;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  assign rgb = {rgb_r, rgb_g, rgb_b};

  hsv_pwm_fader #(
    .CLK_HZ    (24000),
    .CYCLE_MS  (1000),
    .PWM_BITS  (2),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .dir     (dir),
    .RGB_R   (rgb_r),
    .RGB_G   (rgb_g),
    .RGB_B   (rgb_b),
    .sector  (sector),
    .hue_wrap(hue_wrap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic adv_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    int wrap_cnt;
    int wrap_cyc;
    int bad_sec;
    int bad_rgb;
    logic [2:0] exp_rgb;
    logic [2:0] exp_sec;

    rst_n = 1'b0;
    en    = 1'b1;
    dir   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb", rgb, 3'b111);
    check("rst_sector", sector, 3'd0);
    check("rst_wrap", hue_wrap, 1'b0);

    // Forward run from reset.
    rst_n = 1'b1;
    cyc   = 0;
    for (int k = 1; k <= 4; k++) begin
      adv_to(k);
      check("boot_all_off", rgb, 3'b111);
    end
    for (int k = 5; k <= 8; k++) begin
      adv_to(k);
      check("boot_red_on", rgb, 3'b011);
    end

    adv_to(999);
    check("pre_step_sector", sector, 3'd0);
    adv_to(1000);
    check("first_step_sector", sector, 3'd0);
    check("first_step_wrap", hue_wrap, 1'b0);
    for (int k = 1001; k <= 1004; k++) begin
      adv_to(k);
      check("old_level_period", rgb, 3'b011);
    end
    for (int k = 1005; k <= 1012; k++) begin
      adv_to(k);
      exp_rgb = ((k - 1) % 4 == 0) ? 3'b001 : 3'b011;
      check("green_quarter_duty", rgb, exp_rgb);
    end

    wrap_cnt = 0;
    wrap_cyc = -1;
    bad_sec  = 0;
    while (cyc < 24001) begin
      adv_to(cyc + 1);
      exp_sec = (cyc < 24000) ? 3'(cyc / 4000) : 3'd0;
      if (sector !== exp_sec) bad_sec++;
      if (hue_wrap === 1'b1) begin
        wrap_cnt++;
        wrap_cyc = cyc;
      end
    end
    check("fwd_sector_sequence_errors", bad_sec, 0);
    check("fwd_wrap_count", wrap_cnt, 1);
    check("fwd_wrap_cycle", wrap_cyc, 24000);
    check("fwd_sector_after_wrap", sector, 3'd0);

    // Freeze at hue 11 (sector 2, fraction 3): blue on 3/4, green 4/4, red off.
    adv_to(35500);
    check("freeze_entry_sector", sector, 3'd2);
    en      = 1'b0;
    bad_sec = 0;
    bad_rgb = 0;
    for (int k = 35501; k <= 40500; k++) begin
      adv_to(k);
      exp_rgb = ((k - 1) % 4 < 3) ? 3'b100 : 3'b101;
      if (rgb !== exp_rgb) bad_rgb++;
      if (sector !== 3'd2) bad_sec++;
    end
    check("freeze_duty_errors", bad_rgb, 0);
    check("freeze_sector_errors", bad_sec, 0);
    en = 1'b1;
    adv_to(41499);
    check("resume_no_early_step", sector, 3'd2);
    adv_to(41500);
    check("resume_step_at_1000", sector, 3'd3);

    // Async reset mid PWM period in sector 3.
    adv_to(41510);
    check("s3_pattern_before_reset", rgb, 3'b100);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_rgb", rgb, 3'b111);
    check("async_rst_sector", sector, 3'd0);
    check("async_rst_wrap", hue_wrap, 1'b0);

    // Reverse run from reset.
    dir = 1'b0;
    @(posedge clk);
    #1;
    check("held_rst_rgb", rgb, 3'b111);
    rst_n = 1'b1;
    cyc   = 0;
    adv_to(999);
    check("rev_pre_step_sector", sector, 3'd0);
    check("rev_pre_step_wrap", hue_wrap, 1'b0);
    adv_to(1000);
    check("rev_wrap_pulse", hue_wrap, 1'b1);
    check("rev_wrap_sector", sector, 3'd5);
    adv_to(1001);
    check("rev_wrap_one_cycle", hue_wrap, 1'b0);
    for (int k = 1002; k <= 1004; k++) begin
      adv_to(k);
      check("rev_old_level_period", rgb, 3'b011);
    end
    for (int k = 1005; k <= 1012; k++) begin
      adv_to(k);
      exp_rgb = ((k - 1) % 4 == 0) ? 3'b010 : 3'b011;
      check("rev_s5_duty", rgb, exp_rgb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
